pc_gen: RTL and testbench

- Parametrised program-counter / fetch-address generator at the head of the fetch stage.
- Holds the current fetch address and presents it to instruction memory through a valid/ready handshake.
- Advances sequentially on acceptance and takes prioritised redirects from NUM_REDIR sources (exception, branch, jump, ...).
- Tags every request with a wrapping epoch so downstream stages can discard responses fetched before a redirect.

---
 rtl/pc_gen.sv | 91 +++++++++
 tb/tb_pc_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-address generator: holds the PC, issues it over valid/ready, and takes
// prioritised redirects that bump a wrapping epoch tag.
module pc_gen #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    INSTR_BYTES  = 4,
    parameter int                    NUM_REDIR    = 2,
    parameter int                    EPOCH_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            stall,
    input  logic [NUM_REDIR-1:0]            redir_valid,
    input  logic [NUM_REDIR*ADDR_WIDTH-1:0] redir_target,
    input  logic                            fetch_ready,
    output logic                            fetch_valid,
    output logic [ADDR_WIDTH-1:0]           fetch_addr,
    output logic [EPOCH_WIDTH-1:0]          fetch_epoch,
    output logic                            misalign_err
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(INSTR_BYTES);

    logic [0:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
    logic                   err_q, err_d;

    logic                   redir_any;
    logic [ADDR_WIDTH-1:0]  redir_tgt;
    logic                   accept;

    // Scan from the top so the lowest-index set channel is the one left standing.
    always_comb begin
        redir_any = |redir_valid;
        redir_tgt = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) redir_tgt = redir_target[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign accept = valid_q && fetch_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        epoch_d = epoch_q;
        err_d   = 1'b0;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
            valid_d = !stall;
        end else if (redir_any) begin
            // An old-epoch request accepted on this edge still goes out; the tag retires it.
            addr_d  = redir_tgt & ~OFS_MASK;
            epoch_d = epoch_q + EPOCH_WIDTH'(1);
            valid_d = !stall;
            err_d   = |(redir_tgt & OFS_MASK);
        end else begin
            if (accept) addr_d = addr_q + ADDR_INC;
            valid_d = !stall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            addr_q  <= RESET_VECTOR;
            valid_q <= 1'b0;
            epoch_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            epoch_q <= epoch_d;
            err_q   <= err_d;
        end
    end

    assign fetch_valid  = valid_q;
    assign fetch_addr   = addr_q;
    assign fetch_epoch  = epoch_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a per-edge reference model checked every cycle,
// plus literal expectations along the test-plan scenarios.
module tb_pc_gen;
    localparam int AW = 32;
    localparam int IB = 4;
    localparam int NR = 2;
    localparam int EW = 2;
    localparam logic [AW-1:0] RV = 32'h100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          stall = 1'b0;
    logic [NR-1:0] redir_valid = '0;
    logic [NR*AW-1:0] redir_target = '0;
    logic          fetch_ready = 1'b1;
    logic          fetch_valid;
    logic [AW-1:0] fetch_addr;
    logic [EW-1:0] fetch_epoch;
    logic          misalign_err;

    int checks = 0;
    int failures = 0;

    pc_gen #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV), .INSTR_BYTES(IB),
             .NUM_REDIR(NR), .EPOCH_WIDTH(EW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_addr(fetch_addr), .fetch_epoch(fetch_epoch),
        .misalign_err(misalign_err));

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on what each edge must do.
    longint m_addr = 0;
    int     m_epoch = 0;
    bit     m_valid = 0, m_err = 0, m_boot = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot = 1; m_addr = RV; m_valid = 0; m_epoch = 0; m_err = 0;
        end else if (m_boot) begin
            m_boot = 0; m_valid = !stall; m_err = 0;
        end else begin
            int     take;
            longint t;
            bit     acc;
            acc  = m_valid && fetch_ready;
            take = -1;
            for (int i = 0; i < NR; i++)
                if (take < 0 && redir_valid[i]) take = i;
            if (take >= 0) begin
                t       = longint'(redir_target[take*AW +: AW]);
                m_addr  = t - (t % IB);
                m_err   = (t % IB) != 0;
                m_epoch = (m_epoch + 1) % (1 << EW);
            end else begin
                m_err = 0;
                if (acc) m_addr = (m_addr + IB) % (longint'(1) << AW);
            end
            m_valid = !stall;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_valid", 64'(fetch_valid), 64'(m_valid));
        chk("model_addr",  64'(fetch_addr),  64'(m_addr));
        chk("model_epoch", 64'(fetch_epoch), 64'(m_epoch));
        chk("model_err",   64'(misalign_err), 64'(m_err));
    end

    task automatic lit(input string nm, input bit v, input logic [AW-1:0] a,
                       input int e, input bit er);
        chk({nm, "_valid"}, 64'(fetch_valid), 64'(v));
        chk({nm, "_addr"},  64'(fetch_addr),  64'(a));
        chk({nm, "_epoch"}, 64'(fetch_epoch), 64'(e));
        chk({nm, "_err"},   64'(misalign_err), 64'(er));
    endtask

    task automatic set_redir(input int ch, input logic [AW-1:0] a);
        redir_target[ch*AW +: AW] = a;
        redir_valid[ch] = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step(); step();
        lit("reset", 0, 32'h100, 0, 0);
        rst_n = 1'b1;
        lit("boot", 0, 32'h100, 0, 0);
        step(); lit("run0", 1, 32'h100, 0, 0);
        step(); lit("run1", 1, 32'h104, 0, 0);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); lit("bp_hold", 1, 32'h104, 0, 0);
        end
        fetch_ready = 1'b1;
        step(); lit("bp_release", 1, 32'h108, 0, 0);

        set_redir(0, 32'h2000); set_redir(1, 32'h3000);
        step(); lit("redir_prio", 1, 32'h2000, 1, 0);
        redir_valid = '0; set_redir(1, 32'h3002);
        step(); lit("redir_mis", 1, 32'h3000, 2, 1);
        redir_valid = '0;
        step(); lit("mis_clear", 1, 32'h3004, 2, 0);

        stall = 1'b1; set_redir(0, 32'h400);
        step(); lit("stall_redir", 0, 32'h400, 3, 0);
        redir_valid = '0;
        step(); lit("stall_hold", 0, 32'h400, 3, 0);
        stall = 1'b0;
        step(); lit("stall_rel", 1, 32'h400, 3, 0);

        set_redir(0, 32'hFFFF_FFFC);
        step(); lit("wrap_tgt", 1, 32'hFFFF_FFFC, 0, 0);
        redir_valid = '0;
        step(); lit("addr_wrap", 1, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            set_redir(1, 32'h500 + 32'(i * 8));
            step();
        end
        redir_valid = '0;
        lit("epoch_wrap", 1, 32'h518, 0, 0);

        fetch_ready = 1'b0;
        step(); lit("pre_rst", 1, 32'h518, 0, 0);
        #2 rst_n = 1'b0;
        #1 lit("async_rst", 0, 32'h100, 0, 0);
        step();
        rst_n = 1'b1;
        lit("reboot", 0, 32'h100, 0, 0);
        step(); lit("rerun0", 1, 32'h100, 0, 0);
        fetch_ready = 1'b1;
        step(); lit("rerun1", 1, 32'h104, 0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
